rr_bus_arbiter8: RTL and testbench

- Shares one 32-bit result bus among 8 requesters.
- Contains the round-robin controller that generates the 3-bit select for the 8:1 32-bit mux, the mux itself, and a one-entry output register with valid/ready backpressure.
- Sits between execution/memory sources and the single shared writeback/bus consumer.
- Grants are held for bursts of up to MAX_BURST beats, then rotated.

---
 rtl/rr_bus_arbiter8_if.sv | 24 ++
 rtl/rr_bus_arbiter8.sv | 120 ++++++++++++
 tb/tb_rr_bus_arbiter8.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_bus_arbiter8_if.sv
// Handshake bundle between the 8 requesters, the round-robin arbiter and the
// single downstream consumer of the shared result bus.
interface rr_bus_arbiter8_if #(
    parameter int WIDTH = 32
);
    logic [7:0]         req;
    logic [8*WIDTH-1:0] req_data;
    logic [7:0]         gnt;
    logic [2:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_src;
    logic               out_ready;

    modport master (
        output req, req_data, out_ready,
        input  gnt, sel, out_valid, out_data, out_src
    );

    modport slave (
        input  req, req_data, out_ready,
        output gnt, sel, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_bus_arbiter8.sv
// Round-robin arbiter sharing one result bus among 8 requesters: burst-limited
// grants, 8:1 data mux and a one-entry output register with valid/ready.
module rr_bus_arbiter8 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset,
    rr_bus_arbiter8_if.slave   bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         owner_q, owner_d;
    logic [2:0]         last_q, last_d;
    logic [3:0]         burst_cnt_q, burst_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [2:0]         out_src_q, out_src_d;

    logic               slot_free;
    logic               accept;
    logic               release_own;
    logic [2:0]         winner;
    logic               winner_found;
    logic [2:0]         probe;
    logic [WIDTH-1:0]   owner_beat;

    // Search starts one past the last owner so the previous owner ranks last.
    always_comb begin
        winner       = 3'd0;
        winner_found = 1'b0;
        probe        = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            probe = last_q + 3'(i);
            if (!winner_found && bus.req[probe]) begin
                winner       = probe;
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        slot_free   = !out_valid_q || bus.out_ready;
        owner_beat  = bus.req_data[owner_q*WIDTH +: WIDTH];
        // Gating with reset keeps a mid-burst reset from pulsing gnt on a beat it then drops.
        accept      = (state_q == GRANT) && bus.req[owner_q] && slot_free && !reset;
        release_own = (state_q == GRANT) &&
                      (!bus.req[owner_q] ||
                       (accept && (burst_cnt_q == 4'(MAX_BURST - 1))));

        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;

        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    owner_d     = winner;
                    burst_cnt_d = 4'd0;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end
                if (release_own) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new beat replaces the old one even when the consumer takes it this cycle.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = owner_beat;
            out_src_d   = owner_q;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 3'd0;
            last_q      <= 3'd7;
            burst_cnt_q <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign bus.gnt       = accept ? (8'd1 << owner_q) : 8'd0;
    assign bus.sel       = (state_q == GRANT) ? owner_q : 3'd0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// Bench for rr_bus_arbiter8: directed scenarios plus randomized traffic, all
// cycles compared against a behavioural model and an in-order beat scoreboard.
module tb_rr_bus_arbiter8;

    localparam int WIDTH     = 32;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rr_bus_arbiter8_if #(.WIDTH(WIDTH)) bus_if ();

    rr_bus_arbiter8 #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: who owns the bus, how many beats taken, what sits in the output slot.
    bit          m_busy;
    int          m_owner;
    int          m_last;
    int          m_cnt;
    bit          m_ov;
    logic [31:0] m_od;
    int          m_os;
    logic [31:0] sb[$];
    logic [7:0]  last_gnt;

    function automatic int pick(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++)
            if (r[(last + k) % 8]) return (last + k) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = 7;
        m_cnt   = 0;
        m_ov    = 1'b0;
        m_od    = 32'h0;
        m_os    = 0;
        sb.delete();
    endtask

    task automatic tick();
        logic [7:0]  eg;
        bit          acc;
        bit          rel;
        int          w;
        logic [31:0] beat;
        logic [31:0] front;
        @(negedge clk);
        acc = m_busy && !reset && bus_if.req[m_owner] && (!m_ov || bus_if.out_ready);
        eg  = acc ? 8'(1 << m_owner) : 8'h00;
        check_eq("gnt", 64'(bus_if.gnt), 64'(eg));
        check_eq("sel", 64'(bus_if.sel), 64'(m_busy ? m_owner : 0));
        check_eq("out_valid", 64'(bus_if.out_valid), 64'(m_ov));
        check_eq("out_data", 64'(bus_if.out_data), 64'(m_od));
        check_eq("out_src", 64'(bus_if.out_src), 64'(m_os));
        last_gnt = bus_if.gnt;
        if (reset) begin
            model_reset();
        end else begin
            if (m_ov && bus_if.out_ready) begin
                if (sb.size() > 0) begin
                    front = sb.pop_front();
                    check_eq("sb_order", 64'(bus_if.out_data), 64'(front));
                end else begin
                    check_eq("sb_underflow", 64'(sb.size()), 64'd1);
                end
            end
            beat = bus_if.req_data[m_owner*32 +: 32];
            if (acc) begin
                m_ov = 1'b1;
                m_od = beat;
                m_os = m_owner;
                sb.push_back(beat);
            end else if (bus_if.out_ready) begin
                m_ov = 1'b0;
            end
            if (!m_busy) begin
                w = pick(bus_if.req, m_last);
                if (w >= 0) begin
                    m_busy  = 1'b1;
                    m_owner = w;
                    m_cnt   = 0;
                end
            end else begin
                rel = !bus_if.req[m_owner] || (acc && m_cnt == MAX_BURST - 1);
                if (acc) m_cnt++;
                if (rel) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++)
            if (last_gnt[i]) bus_if.req_data[i*32 +: 32] = $urandom;
    endtask

    task automatic reset_seq();
        reset            = 1'b1;
        bus_if.req       = 8'h00;
        bus_if.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        bus_if.req       = 8'h00;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) bus_if.req_data[i*32 +: 32] = $urandom;
        last_gnt = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_seq();

        // Single requester latency
        bus_if.req = 8'h01;
        bus_if.req_data[31:0] = 32'hA5A5_0001;
        tick();
        check_eq("t1_gnt", 64'(bus_if.gnt), 64'h01);
        tick();
        check_eq("t1_valid", 64'(bus_if.out_valid), 64'd1);
        check_eq("t1_data", 64'(bus_if.out_data), 64'hA5A5_0001);
        check_eq("t1_src", 64'(bus_if.out_src), 64'd0);
        bus_if.req = 8'h00;
        tick();

        // All requesting: bursts of MAX_BURST then one bubble, rotating with wrap
        reset_seq();
        bus_if.req = 8'hFF;
        for (int t = 1; t <= 45; t++) begin
            int ph;
            int grp;
            tick();
            ph  = (t - 1) % (MAX_BURST + 1);
            grp = ((t - 1) / (MAX_BURST + 1)) % 8;
            check_eq("rr_gnt", 64'(bus_if.gnt), (ph < MAX_BURST) ? (64'd1 << grp) : 64'd0);
            check_eq("rr_sel", 64'(bus_if.sel), (ph < MAX_BURST) ? 64'(grp) : 64'd0);
        end

        // Owner 3 stalled by the consumer
        reset_seq();
        bus_if.req = 8'h08;
        tick();
        tick();
        bus_if.out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            check_eq("stall_gnt", 64'(bus_if.gnt), 64'h00);
            check_eq("stall_sel", 64'(bus_if.sel), 64'd3);
            check_eq("stall_valid", 64'(bus_if.out_valid), 64'd1);
        end
        bus_if.out_ready = 1'b1;
        repeat (6) tick();
        bus_if.req = 8'h00;
        repeat (2) tick();

        // Owner 5 drops early; search resumes after 5
        reset_seq();
        bus_if.req = 8'h20;
        tick();
        bus_if.req = 8'h64;
        tick();
        tick();
        bus_if.req = 8'h44;
        tick();
        tick();
        check_eq("drop_sel", 64'(bus_if.sel), 64'd6);
        check_eq("drop_gnt", 64'(bus_if.gnt), 64'h40);
        bus_if.req = 8'h00;
        repeat (2) tick();

        // Wrap from 7 to 0
        reset_seq();
        bus_if.req = 8'h80;
        tick();
        check_eq("wrap_gnt7", 64'(bus_if.gnt), 64'h80);
        check_eq("wrap_sel7", 64'(bus_if.sel), 64'd7);
        bus_if.req = 8'h81;
        repeat (5) tick();
        check_eq("wrap_gnt0", 64'(bus_if.gnt), 64'h01);
        check_eq("wrap_sel0", 64'(bus_if.sel), 64'd0);

        // Reset mid-burst with a held beat
        reset_seq();
        bus_if.req = 8'h01;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("rst_valid", 64'(bus_if.out_valid), 64'd0);
        check_eq("rst_gnt", 64'(bus_if.gnt), 64'h00);
        check_eq("rst_sel", 64'(bus_if.sel), 64'd0);
        reset      = 1'b0;
        bus_if.req = 8'h81;
        tick();
        check_eq("rst_first", 64'(bus_if.gnt), 64'h01);

        // Randomized traffic with random backpressure and occasional reset
        for (int c = 0; c < 1500; c++) begin
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 8; i++) begin
                if (last_gnt[i]) bus_if.req[i] = ($urandom_range(0, 2) != 0);
                else if (!bus_if.req[i]) bus_if.req[i] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end

        reset            = 1'b0;
        bus_if.req       = 8'h00;
        bus_if.out_ready = 1'b1;
        repeat (4) tick();
        check_eq("drain_sb", 64'(sb.size()), 64'd0);
        check_eq("drain_valid", 64'(bus_if.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
